mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_if.sv | 50 +++++
 rtl/mem_stage.sv | 130 +++++++++++++
 tb/tb_mem_stage.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// EX->MEM->WB bundle for the memory stage.
// Carries EX request, dcache response, WB result, stall and forwarding.
interface mem_stage_if;
  logic        flush;
  logic        valid_i;
  logic [31:0] pc_i;
  logic [7:0]  aluop_i;
  logic [31:0] addr_i;
  logic        mem_req_i;
  logic [4:0]  is_exception_i;
  logic        reg_write_en_i;
  logic [4:0]  reg_write_addr_i;
  logic [31:0] reg_write_data_i;
  logic        dcache_rvalid_i;
  logic [31:0] dcache_rdata_i;
  logic        valid_o;
  logic [31:0] pc_o;
  logic [4:0]  is_exception_o;
  logic        reg_write_en_o;
  logic [4:0]  reg_write_addr_o;
  logic [31:0] reg_write_data_o;
  logic        pause_mem_o;
  logic        fwd_valid_o;
  logic [4:0]  fwd_addr_o;
  logic [31:0] fwd_data_o;

  modport slave (
    input  flush, valid_i, pc_i, aluop_i, addr_i,
    input  mem_req_i, is_exception_i,
    input  reg_write_en_i, reg_write_addr_i,
    input  reg_write_data_i,
    input  dcache_rvalid_i, dcache_rdata_i,
    output valid_o, pc_o, is_exception_o,
    output reg_write_en_o, reg_write_addr_o,
    output reg_write_data_o, pause_mem_o,
    output fwd_valid_o, fwd_addr_o, fwd_data_o
  );

  modport master (
    output flush, valid_i, pc_i, aluop_i, addr_i,
    output mem_req_i, is_exception_i,
    output reg_write_en_i, reg_write_addr_i,
    output reg_write_data_i,
    output dcache_rvalid_i, dcache_rdata_i,
    input  valid_o, pc_o, is_exception_o,
    input  reg_write_en_o, reg_write_addr_o,
    input  reg_write_data_o, pause_mem_o,
    input  fwd_valid_o, fwd_addr_o, fwd_data_o
  );
endinterface

// File: rtl/mem_stage.sv
// Memory stage: waits for dcache load data, extracts and sign/zero-extends.
// Optional MEM_FWD_EN drives WB forwarding outputs; tied to 0 otherwise.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  mem_stage_if.slave  bus
);

  localparam logic [7:0] OP_LDB  = 8'h20;
  localparam logic [7:0] OP_LDH  = 8'h21;
  localparam logic [7:0] OP_LDW  = 8'h22;
  localparam logic [7:0] OP_LDBU = 8'h23;
  localparam logic [7:0] OP_LDHU = 8'h24;
  localparam logic [7:0] OP_LLW  = 8'h25;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DRAIN
  } state_t;

  state_t      state;
  logic [7:0]  ld_op;
  logic [1:0]  ld_off;
  logic        op_is_ld;
  logic        take_ld;
  logic        addr_unused;

  assign addr_unused = ^bus.addr_i[31:2];

  assign op_is_ld = (bus.aluop_i == OP_LDB)
                 || (bus.aluop_i == OP_LDBU)
                 || (bus.aluop_i == OP_LDH)
                 || (bus.aluop_i == OP_LDHU)
                 || (bus.aluop_i == OP_LDW)
                 || (bus.aluop_i == OP_LLW);

  assign take_ld = op_is_ld && bus.mem_req_i
                && (bus.is_exception_i == 5'd0);

  assign bus.pause_mem_o = (state != IDLE);

  function automatic logic [31:0] extract(
    input logic [7:0]  op,
    input logic [1:0]  off,
    input logic [31:0] w
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[8*off +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    unique case (1'b1)
      (op == OP_LDB):  r = {{24{b[7]}}, b};
      (op == OP_LDBU): r = {24'd0, b};
      (op == OP_LDH):  r = {{16{h[15]}}, h};
      (op == OP_LDHU): r = {16'd0, h};
      default:         r = w;
    endcase
    return r;
  endfunction

  // Stage FSM with registered WB outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                <= IDLE;
      ld_op                <= 8'd0;
      ld_off               <= 2'd0;
      bus.valid_o          <= 1'b0;
      bus.pc_o             <= 32'd0;
      bus.is_exception_o   <= 5'd0;
      bus.reg_write_en_o   <= 1'b0;
      bus.reg_write_addr_o <= 5'd0;
      bus.reg_write_data_o <= 32'd0;
    end else begin
      unique case (state)
        IDLE: begin
          bus.valid_o <= 1'b0;
          if (bus.valid_i && !bus.flush) begin
            bus.pc_o             <= bus.pc_i;
            bus.is_exception_o   <= bus.is_exception_i;
            bus.reg_write_en_o   <= bus.reg_write_en_i;
            bus.reg_write_addr_o <= bus.reg_write_addr_i;
            bus.reg_write_data_o <= bus.reg_write_data_i;
            if (take_ld) begin
              state  <= WAIT;
              ld_op  <= bus.aluop_i;
              ld_off <= bus.addr_i[1:0];
            end else begin
              bus.valid_o <= 1'b1;
            end
          end
        end
        WAIT: begin
          bus.valid_o <= 1'b0;
          if (bus.dcache_rvalid_i) begin
            state <= IDLE;
            if (!bus.flush) begin
              bus.valid_o          <= 1'b1;
              bus.reg_write_data_o <= extract(
                ld_op, ld_off, bus.dcache_rdata_i);
            end
          end else if (bus.flush) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          bus.valid_o <= 1'b0;
          if (bus.dcache_rvalid_i)
            state <= IDLE;
        end
        default: begin
          state       <= IDLE;
          bus.valid_o <= 1'b0;
        end
      endcase
    end
  end

`ifdef MEM_FWD_EN
  assign bus.fwd_valid_o = bus.valid_o & bus.reg_write_en_o;
  assign bus.fwd_addr_o  = bus.reg_write_addr_o;
  assign bus.fwd_data_o  = bus.reg_write_data_o;
`else
  assign bus.fwd_valid_o = 1'b0;
  assign bus.fwd_addr_o  = 5'd0;
  assign bus.fwd_data_o  = 32'd0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
// Hand-computed vectors for pass-through, loads, flush and reset.
module tb_mem_stage;

  localparam logic [7:0] OP_ADDW = 8'h01;
  localparam logic [7:0] OP_LDB  = 8'h20;
  localparam logic [7:0] OP_LDH  = 8'h21;
  localparam logic [7:0] OP_LDW  = 8'h22;
  localparam logic [7:0] OP_LDBU = 8'h23;
  localparam logic [7:0] OP_LDHU = 8'h24;
  localparam logic [7:0] OP_STW  = 8'h28;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  mem_stage_if bus();

  mem_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.flush            = 1'b0;
    bus.valid_i          = 1'b0;
    bus.pc_i             = 32'd0;
    bus.aluop_i          = 8'd0;
    bus.addr_i           = 32'd0;
    bus.mem_req_i        = 1'b0;
    bus.is_exception_i   = 5'd0;
    bus.reg_write_en_i   = 1'b0;
    bus.reg_write_addr_i = 5'd0;
    bus.reg_write_data_i = 32'd0;
    bus.dcache_rvalid_i  = 1'b0;
    bus.dcache_rdata_i   = 32'd0;
  endtask

  task automatic issue(
    input logic [7:0]  op,
    input logic [31:0] pc,
    input logic [31:0] addr,
    input logic        req,
    input logic [4:0]  exc,
    input logic [31:0] wdata
  );
    bus.valid_i          = 1'b1;
    bus.aluop_i          = op;
    bus.pc_i             = pc;
    bus.addr_i           = addr;
    bus.mem_req_i        = req;
    bus.is_exception_i   = exc;
    bus.reg_write_en_i   = 1'b1;
    bus.reg_write_addr_i = 5'd7;
    bus.reg_write_data_i = wdata;
  endtask

  // Load issued, rvalid after one WAIT cycle, check extracted data.
  task automatic load_1wait(
    input string       tag,
    input logic [7:0]  op,
    input logic [31:0] addr,
    input logic [31:0] rdata,
    input logic [31:0] exp
  );
    issue(op, 32'h100, addr, 1'b1, 5'd0, 32'h0);
    tick();
    idle_in();
    bus.dcache_rvalid_i = 1'b1;
    bus.dcache_rdata_i  = rdata;
    tick();
    idle_in();
    check({tag, "_v"}, 32'(bus.valid_o), 32'd1);
    check({tag, "_d"}, bus.reg_write_data_o, exp);
  endtask

  logic exp_fwd;

  initial begin
    n_checks = 0;
    n_errors = 0;
`ifdef MEM_FWD_EN
    exp_fwd = 1'b1;
`else
    exp_fwd = 1'b0;
`endif
    rst = 1'b0;
    idle_in();
    #3;
    check("rst_valid", 32'(bus.valid_o), 32'd0);
    check("rst_pause", 32'(bus.pause_mem_o), 32'd0);
    check("rst_data", bus.reg_write_data_o, 32'd0);
    check("rst_fwd", 32'(bus.fwd_valid_o), 32'd0);
    tick();
    rst = 1'b1;
    tick();

    // ALU op passes through with one cycle latency
    issue(OP_ADDW, 32'h1000, 32'h0, 1'b0, 5'd0, 32'h12345678);
    tick();
    idle_in();
    check("add_valid", 32'(bus.valid_o), 32'd1);
    check("add_data", bus.reg_write_data_o, 32'h12345678);
    check("add_pc", bus.pc_o, 32'h1000);
    check("add_waddr", 32'(bus.reg_write_addr_o), 32'd7);
    check("add_pause", 32'(bus.pause_mem_o), 32'd0);
    check("add_fwd", 32'(bus.fwd_valid_o), 32'(exp_fwd));
    check("add_fwdd", bus.fwd_data_o, exp_fwd ? 32'h12345678 : 32'h0);
    tick();
    check("add_once", 32'(bus.valid_o), 32'd0);

    // LDB at offset 3, rvalid three cycles later
    issue(OP_LDB, 32'h2000, 32'hABCD0003, 1'b1, 5'd0, 32'h0);
    tick();
    idle_in();
    check("ldb_p1", 32'(bus.pause_mem_o), 32'd1);
    check("ldb_v1", 32'(bus.valid_o), 32'd0);
    tick();
    check("ldb_p2", 32'(bus.pause_mem_o), 32'd1);
    tick();
    check("ldb_p3", 32'(bus.pause_mem_o), 32'd1);
    bus.dcache_rvalid_i = 1'b1;
    bus.dcache_rdata_i  = 32'h80FF0000;
    tick();
    idle_in();
    check("ldb_v", 32'(bus.valid_o), 32'd1);
    check("ldb_d", bus.reg_write_data_o, 32'hFFFFFF80);
    check("ldb_pc", bus.pc_o, 32'h2000);
    check("ldb_p4", 32'(bus.pause_mem_o), 32'd0);
    tick();
    check("ldb_once", 32'(bus.valid_o), 32'd0);

    load_1wait("ldhu", OP_LDHU, 32'h2, 32'hBEEF1234, 32'h0000BEEF);
    load_1wait("ldh", OP_LDH, 32'h2, 32'hBEEF1234, 32'hFFFFBEEF);
    load_1wait("ldh0", OP_LDH, 32'h0, 32'hBEEF1234, 32'h00001234);
    load_1wait("ldbu", OP_LDBU, 32'h1, 32'h12348056, 32'h00000080);
    load_1wait("ldb0", OP_LDB, 32'h0, 32'h12348056, 32'h00000056);
    load_1wait("ldw", OP_LDW, 32'h0, 32'hCAFEF00D, 32'hCAFEF00D);
    tick();

    // Store does not wait
    issue(OP_STW, 32'h3000, 32'h40, 1'b1, 5'd0, 32'h55);
    tick();
    idle_in();
    check("stw_v", 32'(bus.valid_o), 32'd1);
    check("stw_p", 32'(bus.pause_mem_o), 32'd0);

    // Load with exception or without a request does not wait
    issue(OP_LDW, 32'h3004, 32'h40, 1'b1, 5'b00010, 32'h0);
    tick();
    idle_in();
    check("ldexc_v", 32'(bus.valid_o), 32'd1);
    check("ldexc_p", 32'(bus.pause_mem_o), 32'd0);
    check("ldexc_e", 32'(bus.is_exception_o), 32'd2);
    issue(OP_LDW, 32'h3008, 32'h40, 1'b0, 5'd0, 32'h0);
    tick();
    idle_in();
    check("ldnrq_v", 32'(bus.valid_o), 32'd1);
    check("ldnrq_p", 32'(bus.pause_mem_o), 32'd0);

    // Flush in IDLE kills the instruction; rvalid in IDLE ignored
    issue(OP_ADDW, 32'h300C, 32'h0, 1'b0, 5'd0, 32'h9);
    bus.flush = 1'b1;
    tick();
    idle_in();
    check("iflush_v", 32'(bus.valid_o), 32'd0);
    bus.dcache_rvalid_i = 1'b1;
    tick();
    idle_in();
    check("irv_v", 32'(bus.valid_o), 32'd0);
    check("irv_p", 32'(bus.pause_mem_o), 32'd0);

    // Flush in WAIT without rvalid: DRAIN until rvalid
    issue(OP_LDW, 32'h4000, 32'h0, 1'b1, 5'd0, 32'h0);
    tick();
    idle_in();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("drn_p1", 32'(bus.pause_mem_o), 32'd1);
    check("drn_v1", 32'(bus.valid_o), 32'd0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("drn_p2", 32'(bus.pause_mem_o), 32'd1);
    bus.dcache_rvalid_i = 1'b1;
    bus.dcache_rdata_i  = 32'h11111111;
    tick();
    idle_in();
    check("drn_p3", 32'(bus.pause_mem_o), 32'd0);
    check("drn_v3", 32'(bus.valid_o), 32'd0);
    tick();
    check("drn_v4", 32'(bus.valid_o), 32'd0);

    // Flush and rvalid together in WAIT: discard, back to IDLE
    issue(OP_LDW, 32'h5000, 32'h0, 1'b1, 5'd0, 32'h0);
    tick();
    idle_in();
    bus.flush           = 1'b1;
    bus.dcache_rvalid_i = 1'b1;
    bus.dcache_rdata_i  = 32'h22222222;
    tick();
    idle_in();
    check("frv_v", 32'(bus.valid_o), 32'd0);
    check("frv_p", 32'(bus.pause_mem_o), 32'd0);

    // Reset during WAIT, then excepted store passes straight through
    issue(OP_LDW, 32'h6000, 32'h0, 1'b1, 5'd0, 32'h0);
    tick();
    idle_in();
    check("wrst_p0", 32'(bus.pause_mem_o), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("wrst_p", 32'(bus.pause_mem_o), 32'd0);
    check("wrst_pc", bus.pc_o, 32'd0);
    check("wrst_v", 32'(bus.valid_o), 32'd0);
    tick();
    rst = 1'b1;
    issue(OP_STW, 32'h6004, 32'h8, 1'b1, 5'b00001, 32'h0);
    tick();
    idle_in();
    check("xst_v", 32'(bus.valid_o), 32'd1);
    check("xst_e", 32'(bus.is_exception_o), 32'd1);
    check("xst_p", 32'(bus.pause_mem_o), 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
